// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-ported data memory,
// with a window check, a bounded lock for atomic sequences and 1-cycle responses.
module dmem_arbiter #(
   parameter int unsigned LOCK_MAX = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_lock,
   input  logic [31:0] m0_addr,
   input  logic [3:0]  m0_we,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic        m1_lock,
   input  logic [31:0] m1_addr,
   input  logic [3:0]  m1_we,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic        mem_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_d,
   output logic [3:0]  mem_we,
   input  logic [31:0] mem_q
);

   localparam logic [8:0] LOCK_LIM = 9'(LOCK_MAX);

   function automatic logic in_window(input logic [31:0] a);
      return (a[31:23] == 9'h001);
   endfunction

   logic       last_q;
   logic       locked_q;
   logic       owner_q;
   logic [7:0] lock_cnt_q;
   logic [1:0] owe_err_q;

   logic       last_d;
   logic       locked_d;
   logic       owner_d;
   logic [7:0] lock_cnt_d;
   logic [1:0] owe_err_d;

   logic       rsp_vld_p1;
   logic       rsp_port_p1;
   logic       rsp_err_p1;
   logic       rsp_hit_p1;

   logic        gnt0;
   logic        gnt1;
   logic        gnt_any;
   logic        sel;
   logic        sel_lock;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [3:0]  sel_we;
   logic        hit;
   logic [8:0]  cnt_inc;

   // Stage p0: grant decision and memory request
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (locked_q) begin
         gnt0 = m0_req && !owner_q;
         gnt1 = m1_req && owner_q;
      end else if (m0_req && m1_req) begin
         gnt0 = last_q;
         gnt1 = !last_q;
      end else begin
         gnt0 = m0_req;
         gnt1 = m1_req;
      end
   end

   assign gnt_any   = gnt0 | gnt1;
   assign sel       = gnt1;
   assign sel_lock  = sel ? m1_lock  : m0_lock;
   assign sel_addr  = sel ? m1_addr  : m0_addr;
   assign sel_wdata = sel ? m1_wdata : m0_wdata;
   assign sel_we    = sel ? m1_we    : m0_we;
   assign hit       = gnt_any && in_window(sel_addr);

   assign m0_gnt   = gnt0;
   assign m1_gnt   = gnt1;
   assign mem_en   = hit;
   assign mem_addr = hit ? sel_addr  : 32'd0;
   assign mem_d    = hit ? sel_wdata : 32'd0;
   assign mem_we   = hit ? sel_we    : 4'd0;

   assign cnt_inc = {1'b0, lock_cnt_q} + 9'd1;

   // A voluntary release by the owner takes priority over the timeout on the same edge.
   always_comb begin
      last_d     = last_q;
      locked_d   = locked_q;
      owner_d    = owner_q;
      lock_cnt_d = lock_cnt_q;
      owe_err_d  = owe_err_q;
      if (gnt_any) begin
         last_d         = sel;
         owe_err_d[sel] = 1'b0;
      end
      if (locked_q) begin
         if (gnt_any && !sel_lock) begin
            locked_d   = 1'b0;
            lock_cnt_d = 8'd0;
         end else if (cnt_inc >= LOCK_LIM) begin
            locked_d             = 1'b0;
            lock_cnt_d           = 8'd0;
            owe_err_d[owner_q]   = 1'b1;
            last_d               = owner_q;
         end else begin
            lock_cnt_d = cnt_inc[7:0];
         end
      end else if (gnt_any && sel_lock) begin
         locked_d   = 1'b1;
         owner_d    = sel;
         lock_cnt_d = 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q     <= 1'b1;
         locked_q   <= 1'b0;
         owner_q    <= 1'b0;
         lock_cnt_q <= 8'd0;
         owe_err_q  <= 2'b00;
      end else begin
         last_q     <= last_d;
         locked_q   <= locked_d;
         owner_q    <= owner_d;
         lock_cnt_q <= lock_cnt_d;
         owe_err_q  <= owe_err_d;
      end
   end

   // Stage p1: response routing, captured at the grant edge
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_vld_p1  <= 1'b0;
         rsp_port_p1 <= 1'b0;
         rsp_err_p1  <= 1'b0;
         rsp_hit_p1  <= 1'b0;
      end else begin
         rsp_vld_p1  <= gnt_any;
         rsp_port_p1 <= sel;
         rsp_err_p1  <= gnt_any && (!hit || owe_err_q[sel]);
         rsp_hit_p1  <= hit;
      end
   end

   assign m0_rvalid = rsp_vld_p1 && !rsp_port_p1;
   assign m1_rvalid = rsp_vld_p1 && rsp_port_p1;
   assign m0_err    = m0_rvalid && rsp_err_p1;
   assign m1_err    = m1_rvalid && rsp_err_p1;
   assign m0_rdata  = (m0_rvalid && rsp_hit_p1) ? mem_q : 32'd0;
   assign m1_rdata  = (m1_rvalid && rsp_hit_p1) ? mem_q : 32'd0;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single-ported, synchronous-read data memory between the CPU data port (port 0) and a secondary master (port 1: debug/loader/DMA). Per-cycle round-robin grant, in-range address check for the data memory window, and a bounded lock for atomic read-modify-write sequences. Sits between the masters and the data memory in the top level. Every granted access gets a one-cycle-later response.

## Interface
Parameters:
- LOCK_MAX, 16: maximum consecutive cycles a port may hold the lock before forced release (1..255).

Ports (clock and reset first):
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- mN_req  in  1  port N (N=0,1) access request for this cycle.
- mN_lock  in  1  port N requests the arbiter stay locked to it after this access.
- mN_addr  in  32  byte address.
- mN_we  in  4  byte write enables; 0 = read.
- mN_wdata  in  32  write data.
- mN_gnt  out  1  combinational: port N's request is accepted this cycle.
- mN_rvalid  out  1  registered: response for port N's access granted last cycle.
- mN_rdata  out  32  read word (memory contents before any write in that access); valid with rvalid.
- mN_err  out  1  with rvalid: access was out of range or lock was force-released.
- mem_en  out  1  memory enable.
- mem_addr  out  32  memory address.
- mem_d  out  32  memory write data.
- mem_we  out  4  memory byte enables.
- mem_q  in  32  memory read data, one cycle after mem_en.

## Operation
- At most one grant per cycle. gnt is asserted in the same cycle as req.
- Unlocked, one requester: that requester is granted.
- Unlocked, both requesting: grant the port that was not granted last. The last-grant pointer updates on every grant.
- Reset: pointer = 1, so port 0 wins the first contention. Lock cleared, lock counter = 0, all rvalid/err = 0, rdata = 0.
- Granted access, in range (addr[31:23] == 9'h001):
  - mem_en = 1, mem_addr/mem_d/mem_we = the granted port's signals.
  - Next cycle: rvalid = 1, rdata = mem_q, err = 0.
- Granted access, out of range:
  - mem_en = 0. Next cycle: rvalid = 1, rdata = 0, err = 1.
- No grant: mem_en = 0, mem_we = 0, mem_addr/mem_d = 0.
- Lock state, one owner bit plus locked flag:
  - Set when a granted access has lock = 1. Owner = the granted port. Counter loads 0.
  - While locked, only the owner can be granted. The other port's gnt = 0 even if the owner is idle.
  - Cleared at the end of any cycle in which the owner is granted with lock = 0. That access itself completes normally.
  - Counter increments every locked cycle. When it reaches LOCK_MAX, the lock is force-released at that edge.
  - Forced release: the owner's next granted access returns err = 1 (data still valid if in range), and the pointer is set to favor the non-owner.
  - An owner access in the cycle of forced release is still granted. It is the last locked access.
- Writes also produce rvalid. rdata carries the pre-write word.
- Read-after-write to the same address by either port in consecutive cycles returns the new data (memory ordering).

## Timing
- Grant and mem_* paths are combinational from req/addr/we/wdata/lock and the registered state. No combinational path from mem_q to gnt.
- Response latency: exactly 1 cycle after gnt, for every granted access. Back-to-back grants give back-to-back rvalid.
- Response routing uses a registered port select plus an error bit, captured at the grant edge.
- Reset mid-access: an access granted in the cycle rst is high produces no rvalid. Lock is dropped.
- Requests are not queued. An ungranted master must hold req/addr/we/wdata until gnt.
- Simultaneous lock release by the owner and request by the other port: owner granted this cycle, other port granted next cycle.

## Test plan
- After reset, m0 and m1 both read 0x00800010 every cycle for 4 cycles → grants alternate m0, m1, m0, m1; each rvalid is one cycle later with the preloaded word.
- m1 writes 0xDEADBEEF with we = 4'b0011 to 0x00800020, then m0 reads it → m1 rdata = old word; m0 rdata low half = 0xBEEF, high half unchanged.
- m0 reads 0x00000100 → mem_en = 0; next cycle m0_rvalid = 1, m0_err = 1, m0_rdata = 0.
- m0 locked read, then m1 requests continuously, then m0 write with lock = 0 after 3 idle cycles → m1_gnt = 0 throughout the lock; m1 granted the cycle after the unlocking write.
- LOCK_MAX = 4, m0 locks and goes idle, m1 requesting → m1 granted on the 5th cycle after the lock edge; m0's next access returns err = 1.
- rst asserted in a granted cycle → no rvalid the following cycle; all outputs at reset values.
